// File: rtl/i2s_tx_serializer_if.sv
// Sample-fetch and I2S output bundle of the I2S transmit serializer.
// The serializer is the master: it strobes ready, takes sample_in and drives the DAC lines.
interface i2s_tx_serializer_if #(
    parameter int SAMPLE_W = 16
);
    logic [SAMPLE_W-1:0] sample_in;
    logic                ready;
    logic                i2s_bclk;
    logic                i2s_lrclk;
    logic                i2s_sdata;
    logic                frame_start;

    modport master (
        input  sample_in,
        output ready, i2s_bclk, i2s_lrclk, i2s_sdata, frame_start
    );

    modport slave (
        output sample_in,
        input  ready, i2s_bclk, i2s_lrclk, i2s_sdata, frame_start
    );
endinterface

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: fetches 16-bit samples via a ready strobe and serialises them
// MSB first with a one-BCLK-early LRCLK transition; all timing derived from clk.
module i2s_tx_serializer #(
    parameter int CLK_DIV    = 4,
    parameter int SLOT_WIDTH = 16,
    parameter int MONO_DUP   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    i2s_tx_serializer_if.master   bus
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(SLOT_WIDTH);
    localparam int RW = $clog2(2 * CLK_DIV);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [RW-1:0]         rdy_cnt;
    logic                  ch_q;
    logic                  bclk_q;
    logic                  lrclk_q;
    logic                  ready_q;
    logic                  fetched_q;
    logic                  fs_q;
    logic [SLOT_WIDTH-1:0] shift_q;
    logic [SLOT_WIDTH-1:0] hold_q;

    logic          div_wrap, fall_ev, slot_end, stop, fetch_slot;
    logic [BW-1:0] bit_nxt;

    always_comb begin
        div_wrap   = 1'b0;
        fall_ev    = 1'b0;
        slot_end   = 1'b0;
        stop       = 1'b0;
        fetch_slot = (MONO_DUP == 0) ? 1'b1 : ch_q;
        bit_nxt    = (bit_cnt == BW'(SLOT_WIDTH - 1)) ? '0 : bit_cnt + 1'b1;
        state_d    = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable)
                    state_d = S_RUN;
            end
            S_RUN: begin
                div_wrap = (div_cnt == DW'(CLK_DIV - 1));
                fall_ev  = div_wrap && bclk_q;
                slot_end = fall_ev && (bit_cnt == BW'(SLOT_WIDTH - 1));
                stop     = slot_end && ch_q && !enable;
                if (stop)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            rdy_cnt   <= '0;
            ch_q      <= 1'b0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            ready_q   <= 1'b0;
            fetched_q <= 1'b0;
            fs_q      <= 1'b0;
            shift_q   <= '0;
            hold_q    <= '0;
        end else if (state_q == S_IDLE) begin
            // first slot after entry sends the holding register without waiting for a fall event
            if (enable)
                shift_q <= hold_q;
        end else if (stop) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            rdy_cnt   <= '0;
            ch_q      <= 1'b0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            ready_q   <= 1'b0;
            fetched_q <= 1'b0;
            fs_q      <= 1'b0;
            shift_q   <= '0;
        end else begin
            fs_q    <= 1'b0;
            div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
            if (div_wrap)
                bclk_q <= ~bclk_q;

            if (ready_q) begin
                if (rdy_cnt == RW'(2 * CLK_DIV - 1))
                    ready_q <= 1'b0;
                else
                    rdy_cnt <= rdy_cnt + 1'b1;
            end

            if (fall_ev) begin
                bit_cnt <= bit_nxt;
                if (slot_end) begin
                    ch_q      <= ~ch_q;
                    fetched_q <= 1'b0;
                    shift_q   <= hold_q;
                    fs_q      <= ch_q;
                end else begin
                    shift_q <= {shift_q[SLOT_WIDTH-2:0], 1'b0};
                end
                if (bit_nxt == BW'(SLOT_WIDTH - 1))
                    lrclk_q <= ~ch_q;
                if (bit_nxt == BW'(SLOT_WIDTH / 2) && fetch_slot && enable) begin
                    ready_q   <= 1'b1;
                    rdy_cnt   <= '0;
                    fetched_q <= 1'b1;
                end
                if (bit_nxt == BW'(SLOT_WIDTH - 2) && fetched_q)
                    hold_q <= bus.sample_in;
            end
        end
    end

    assign bus.ready       = ready_q;
    assign bus.i2s_bclk    = bclk_q;
    assign bus.i2s_lrclk   = lrclk_q;
    assign bus.i2s_sdata   = shift_q[SLOT_WIDTH-1];
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench: three serializer configurations decoded by an I2S receiver model.
module tb_i2s_tx_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n0, rst_n1, rst_n2;
    logic en0, en1, en2;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    i2s_tx_serializer_if if0 ();
    i2s_tx_serializer_if if1 ();
    i2s_tx_serializer_if if2 ();

    i2s_tx_serializer #(.CLK_DIV(4), .SLOT_WIDTH(16), .MONO_DUP(1)) u0 (
        .clk(clk), .rst_n(rst_n0), .enable(en0), .bus(if0));
    i2s_tx_serializer #(.CLK_DIV(4), .SLOT_WIDTH(16), .MONO_DUP(0)) u1 (
        .clk(clk), .rst_n(rst_n1), .enable(en1), .bus(if1));
    i2s_tx_serializer #(.CLK_DIV(2), .SLOT_WIDTH(16), .MONO_DUP(1)) u2 (
        .clk(clk), .rst_n(rst_n2), .enable(en2), .bus(if2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sample_for(input int i, input int k);
        logic [15:0] s;
        s = 16'h0000;
        case (i)
            0: case (k) 0: s = 16'hA5C3; 1: s = 16'h3C96; 2: s = 16'h7E81; default: s = 16'h0001; endcase
            1: case (k) 0: s = 16'h0BAD; 1: s = 16'h1234; 2: s = 16'hFEDC; default: s = 16'h5A5A; endcase
            default: case (k) 0: s = 16'hC001; 1: s = 16'h8421; 2: s = 16'h6666; default: s = 16'h9F0E; endcase
        endcase
        return s;
    endfunction

    logic [2:0]  bclk_a, lr_a, sd_a, rdy_a, fs_a, rst_a;
    logic [2:0]  bclk_p = '0, lr_p = '0, lrb_p = '0, rdy_p = '0;
    logic [15:0] smp[3];
    logic [15:0] acc[3];
    logic [15:0] words[3][16];
    logic        wch[3][16];
    int wcnt[3], sptr[3], t_br[3], bper[3], bhigh[3];
    int t_fs[3], fs_per[3], fs_n[3], t_lr[3], lr_per[3], rdy_len[3], rdy_w[3], rdy_n[3];

    assign bclk_a = {if2.i2s_bclk, if1.i2s_bclk, if0.i2s_bclk};
    assign lr_a   = {if2.i2s_lrclk, if1.i2s_lrclk, if0.i2s_lrclk};
    assign sd_a   = {if2.i2s_sdata, if1.i2s_sdata, if0.i2s_sdata};
    assign rdy_a  = {if2.ready, if1.ready, if0.ready};
    assign fs_a   = {if2.frame_start, if1.frame_start, if0.frame_start};
    assign rst_a  = {rst_n2, rst_n1, rst_n0};
    assign if0.sample_in = smp[0];
    assign if1.sample_in = smp[1];
    assign if2.sample_in = smp[2];

    initial begin
        for (int i = 0; i < 3; i++) begin
            smp[i] = '0; acc[i] = '0; sptr[i] = 0;
        end
    end

    always @(posedge clk) cyc++;

    // Receiver model: a word is complete at the BCLK rise where LRCLK differs from the previous rise.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_a[i]) begin
                acc[i] = '0; wcnt[i] = 0; t_br[i] = 0; bper[i] = 0; bhigh[i] = 0;
                t_fs[i] = 0; fs_per[i] = 0; fs_n[i] = 0; t_lr[i] = 0; lr_per[i] = 0;
                rdy_len[i] = 0; rdy_w[i] = 0; rdy_n[i] = 0; lrb_p[i] = 1'b0;
            end else begin
                if (bclk_a[i] && !bclk_p[i]) begin
                    if (t_br[i] != 0) bper[i] = cyc - t_br[i];
                    t_br[i] = cyc;
                    acc[i] = {acc[i][14:0], sd_a[i]};
                    if (lr_a[i] != lrb_p[i]) begin
                        if (wcnt[i] < 16) begin
                            words[i][wcnt[i]] = acc[i];
                            wch[i][wcnt[i]]   = lrb_p[i];
                        end
                        wcnt[i]++;
                    end
                    lrb_p[i] = lr_a[i];
                end
                if (!bclk_a[i] && bclk_p[i]) bhigh[i] = cyc - t_br[i];
                if (lr_a[i] && !lr_p[i]) begin
                    if (t_lr[i] != 0) lr_per[i] = cyc - t_lr[i];
                    t_lr[i] = cyc;
                end
                if (fs_a[i]) begin
                    if (t_fs[i] != 0) fs_per[i] = cyc - t_fs[i];
                    t_fs[i] = cyc;
                    fs_n[i]++;
                end
                if (rdy_a[i]) rdy_len[i]++;
                if (rdy_a[i] && !rdy_p[i]) begin
                    smp[i] = sample_for(i, sptr[i]);
                    sptr[i]++;
                end
                if (!rdy_a[i] && rdy_p[i]) begin
                    rdy_w[i] = rdy_len[i];
                    rdy_len[i] = 0;
                    rdy_n[i]++;
                end
            end
            bclk_p[i] = bclk_a[i];
            lr_p[i]   = lr_a[i];
            rdy_p[i]  = rdy_a[i];
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        logic [4:0] orv;
        rst_n0 = 1'b0; rst_n1 = 1'b0; rst_n2 = 1'b0;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        #12;
        check("u0 reset outs", {27'd0, bclk_a[0], lr_a[0], sd_a[0], rdy_a[0], fs_a[0]}, 32'd0);
        check("u1 reset outs", {27'd0, bclk_a[1], lr_a[1], sd_a[1], rdy_a[1], fs_a[1]}, 32'd0);
        check("u2 reset outs", {27'd0, bclk_a[2], lr_a[2], sd_a[2], rdy_a[2], fs_a[2]}, 32'd0);
        @(negedge clk);
        rst_n0 = 1'b1; rst_n1 = 1'b1; rst_n2 = 1'b1;
        en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;

        fork
            begin : br_u0
                for (k = 0; k < 2000 && wcnt[0] < 4; k++) @(negedge clk);
                check("u0 wait 4 words", {31'd0, wcnt[0] >= 4}, 32'd1);
                check("u0 w0", {16'd0, words[0][0]}, 32'h0000);
                check("u0 w1", {16'd0, words[0][1]}, 32'h0000);
                check("u0 w2 L", {15'd0, wch[0][2], words[0][2]}, 32'h0_A5C3);
                check("u0 w3 R", {15'd0, wch[0][3], words[0][3]}, 32'h1_A5C3);
                check("u0 bclk period", bper[0], 32'd8);
                check("u0 bclk high", bhigh[0], 32'd4);
                for (k = 0; k < 1000 && fs_n[0] < 3; k++) @(negedge clk);
                check("u0 wait fs3", {31'd0, fs_n[0] >= 3}, 32'd1);
                check("u0 frame_start period", fs_per[0], 32'd256);
                check("u0 lrclk period", lr_per[0], 32'd256);
                check("u0 ready width", rdy_w[0], 32'd8);
                check("u0 ready count", rdy_n[0], 32'd3);
                repeat (44) @(negedge clk);
                en0 = 1'b0;
                for (k = 0; k < 1000 && wcnt[0] < 8; k++) @(negedge clk);
                check("u0 wait 8 words", {31'd0, wcnt[0] >= 8}, 32'd1);
                check("u0 w4", {15'd0, wch[0][4], words[0][4]}, 32'h0_3C96);
                check("u0 w5", {15'd0, wch[0][5], words[0][5]}, 32'h1_3C96);
                check("u0 w6", {15'd0, wch[0][6], words[0][6]}, 32'h0_7E81);
                check("u0 w7", {15'd0, wch[0][7], words[0][7]}, 32'h1_7E81);
                repeat (12) @(negedge clk);
                orv = '0;
                for (int j = 0; j < 40; j++) begin
                    orv = orv | {bclk_a[0], lr_a[0], sd_a[0], rdy_a[0], fs_a[0]};
                    @(negedge clk);
                end
                check("u0 idle outs", {27'd0, orv}, 32'd0);
                check("u0 no ready after drop", rdy_n[0], 32'd3);
                check("u0 no words after stop", wcnt[0], 32'd8);
            end
            begin : br_u1
                for (k = 0; k < 2000 && wcnt[1] < 5; k++) @(negedge clk);
                check("u1 wait 5 words", {31'd0, wcnt[1] >= 5}, 32'd1);
                check("u1 w0", {15'd0, wch[1][0], words[1][0]}, 32'h0_0000);
                check("u1 w1", {15'd0, wch[1][1], words[1][1]}, 32'h1_0BAD);
                check("u1 w2 L", {15'd0, wch[1][2], words[1][2]}, 32'h0_1234);
                check("u1 w3 R", {15'd0, wch[1][3], words[1][3]}, 32'h1_FEDC);
                check("u1 w4", {15'd0, wch[1][4], words[1][4]}, 32'h0_5A5A);
                check("u1 ready width", rdy_w[1], 32'd8);
            end
            begin : br_u2
                for (k = 0; k < 2000 && wcnt[2] < 4; k++) @(negedge clk);
                check("u2 wait 4 words", {31'd0, wcnt[2] >= 4}, 32'd1);
                check("u2 w1", {16'd0, words[2][1]}, 32'h0000);
                check("u2 w2", {15'd0, wch[2][2], words[2][2]}, 32'h0_C001);
                check("u2 w3", {15'd0, wch[2][3], words[2][3]}, 32'h1_C001);
                check("u2 bclk period", bper[2], 32'd4);
                check("u2 ready width", rdy_w[2], 32'd4);
                for (k = 0; k < 500 && rdy_a[2]; k++) @(negedge clk);
                for (k = 0; k < 500 && !rdy_a[2]; k++) @(negedge clk);
                @(negedge clk);
                check("u2 ready before rst", {31'd0, rdy_a[2]}, 32'd1);
                #2;
                rst_n2 = 1'b0;
                #1;
                check("u2 async rst outs", {27'd0, bclk_a[2], lr_a[2], sd_a[2], rdy_a[2], fs_a[2]}, 32'd0);
                #20;
                rst_n2 = 1'b1;
                for (k = 0; k < 2000 && wcnt[2] < 3; k++) @(negedge clk);
                check("u2 wait words after rst", {31'd0, wcnt[2] >= 3}, 32'd1);
                check("u2 post-rst w0", {15'd0, wch[2][0], words[2][0]}, 32'h0_0000);
                check("u2 post-rst w1", {15'd0, wch[2][1], words[2][1]}, 32'h1_0000);
                check("u2 post-rst w2", {15'd0, wch[2][2], words[2][2]}, 32'h0_9F0E);
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
